// File: rtl/visu_pkg.sv
// Shared types and sizes for the spectrum visualiser datapath.
package visu_pkg;

  localparam int NUM_BINS = 16;
  localparam int DATA_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_UPDATE,
    ST_DONE
  } peak_state_e;

  typedef logic [NUM_BINS-1:0][DATA_W-1:0] bin_array_t;

endpackage

// File: rtl/bin_peak_cell.sv
// One bin of the peak-hold datapath: abs with saturation, geometric decay, max.
module bin_peak_cell #(
  parameter int DATA_W      = 16,
  parameter int DECAY_SHIFT = 3
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_held,
  input  logic              i_hold_en,
  input  logic              i_tick,
  output logic [DATA_W-1:0] o_held
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] dec;
  logic [DATA_W-1:0] decayed;
  logic [DATA_W-1:0] base;

  // Magnitude, decay step (floored at 1) and the resulting held value.
  always_comb begin
    mag     = i_data;
    dec     = i_held >> DECAY_SHIFT;
    decayed = '0;
    base    = i_held;
    o_held  = '0;

    if (i_data[DATA_W-1]) begin
      mag = (i_data == MOST_NEG) ? MOST_POS : (~i_data + DATA_W'(1));
    end

    if (dec == '0) begin
      dec = DATA_W'(1);
    end
    if (i_held > dec) begin
      decayed = i_held - dec;
    end
    if (i_tick) begin
      base = decayed;
    end

    if (i_hold_en) begin
      o_held = (mag > base) ? mag : base;
    end else begin
      o_held = mag;
    end
  end

endmodule

// File: rtl/spectrum_peak_hold.sv
// Collects a serial frame of signed FFT bins, applies per-bin peak-hold with
// periodic decay and presents the frame in parallel with a done pulse.
module spectrum_peak_hold #(
  parameter int NUM_BINS     = visu_pkg::NUM_BINS,
  parameter int DATA_W       = visu_pkg::DATA_W,
  parameter int DECAY_SHIFT  = 3,
  parameter int DECAY_PERIOD = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_bin_valid,
  input  logic                             i_bin_sop,
  input  logic [DATA_W-1:0]                i_bin_data,
  output logic                             o_bin_ready,
  input  logic                             i_hold_en,
  output logic [NUM_BINS-1:0][DATA_W-1:0]  o_fft_data,
  output logic                             o_fft_done
);

  import visu_pkg::*;

  localparam int IDX_W = $clog2(NUM_BINS);
  localparam int CNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0] LAST_FRM  = CNT_W'(DECAY_PERIOD - 1);

  peak_state_e                       state;
  logic [IDX_W-1:0]                  idx;
  logic [CNT_W-1:0]                  frame_cnt;
  logic [NUM_BINS-1:0][DATA_W-1:0]   staging;
  logic [NUM_BINS-1:0][DATA_W-1:0]   next_held;
  logic                              tick;
  logic                              accept;

  // Decay tick for the frame currently being updated.
  always_comb begin
    tick   = (frame_cnt == LAST_FRM);
    accept = i_bin_valid && o_bin_ready;
  end

  for (genvar g = 0; g < NUM_BINS; g++) begin : g_cell
    bin_peak_cell #(
      .DATA_W      (DATA_W),
      .DECAY_SHIFT (DECAY_SHIFT)
    ) u_cell (
      .i_data    (staging[g]),
      .i_held    (o_fft_data[g]),
      .i_hold_en (i_hold_en),
      .i_tick    (tick),
      .o_held    (next_held[g])
    );
  end

  // Frame FSM: collect bins, update all held values at once, pulse done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      frame_cnt   <= '0;
      staging     <= '0;
      o_fft_data  <= '0;
      o_fft_done  <= 1'b0;
      o_bin_ready <= 1'b1;
    end else begin
      o_fft_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && i_bin_sop) begin
            staging[0] <= i_bin_data;
            idx        <= IDX_W'(1);
            state      <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            if (i_bin_sop) begin
              staging[0] <= i_bin_data;
              idx        <= IDX_W'(1);
            end else begin
              staging[idx] <= i_bin_data;
              if (idx == LAST_IDX) begin
                idx         <= '0;
                state       <= ST_UPDATE;
                o_bin_ready <= 1'b0;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
        end
        ST_UPDATE: begin
          o_fft_data <= next_held;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          o_fft_done  <= 1'b1;
          o_bin_ready <= 1'b1;
          frame_cnt   <= (frame_cnt == LAST_FRM) ? '0 : frame_cnt + CNT_W'(1);
          state       <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          o_bin_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_peak_hold.sv
// Directed scoreboard bench for spectrum_peak_hold.
module tb_spectrum_peak_hold;
  import visu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_bin_valid;
  logic        i_bin_sop;
  logic [15:0] i_bin_data;
  logic        o_bin_ready;
  logic        i_hold_en;
  bin_array_t  o_fft_data;
  logic        o_fft_done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  bin_array_t  sb [$];
  logic [15:0] stim [16];
  bin_array_t  expv;

  int unsigned hold_e0 [12] = '{800, 800, 800, 700, 700, 700, 700, 613, 613, 613, 613, 537};
  int unsigned hold_e1 [12] = '{5, 5, 5, 4, 4, 4, 4, 3, 3, 3, 3, 2};

  spectrum_peak_hold #(
    .NUM_BINS     (16),
    .DATA_W       (16),
    .DECAY_SHIFT  (3),
    .DECAY_PERIOD (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_bin_valid (i_bin_valid),
    .i_bin_sop   (i_bin_sop),
    .i_bin_data  (i_bin_data),
    .o_bin_ready (o_bin_ready),
    .i_hold_en   (i_hold_en),
    .o_fft_data  (o_fft_data),
    .o_fft_done  (o_fft_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected frame.
  always @(negedge i_clk) begin
    if (o_fft_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        bin_array_t e;
        e = sb.pop_front();
        for (int k = 0; k < 16; k++) begin
          chk($sformatf("bin%0d", k), 32'(o_fft_data[k]), 32'(e[k]));
        end
      end
    end
  end

  task automatic tick_wait();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bin(input logic sop, input logic [15:0] d);
    int unsigned g;
    g = 0;
    i_bin_valid = 1'b1;
    i_bin_sop   = sop;
    i_bin_data  = d;
    while (o_bin_ready !== 1'b1 && g < 20) begin
      tick_wait();
      g++;
    end
    if (o_bin_ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
    tick_wait();
    i_bin_valid = 1'b0;
    i_bin_sop   = 1'b0;
  endtask

  task automatic drain();
    int unsigned g;
    g = 0;
    while (sb.size() != 0 && g < 10) begin
      tick_wait();
      g++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Sends stim[0..15] as one frame and queues expv as its expected result.
  task automatic run_frame(input logic timing, input logic junk);
    for (int k = 0; k < 15; k++) send_bin(k == 0, stim[k]);
    sb.push_back(expv);
    send_bin(1'b0, stim[15]);
    if (junk) begin
      i_bin_valid = 1'b1;
      i_bin_sop   = 1'b0;
      i_bin_data  = 16'h7777;
    end
    if (timing) begin
      chk("ready_n0", 32'(o_bin_ready), 32'd0);
      chk("done_n0", 32'(o_fft_done), 32'd0);
      tick_wait();
      chk("ready_n1", 32'(o_bin_ready), 32'd0);
      chk("done_n1", 32'(o_fft_done), 32'd0);
      chk("data_n1_b5", 32'(o_fft_data[5]), 32'(expv[5]));
      tick_wait();
      chk("done_n2", 32'(o_fft_done), 32'd1);
      chk("ready_n2", 32'(o_bin_ready), 32'd1);
      tick_wait();
      chk("done_n3", 32'(o_fft_done), 32'd0);
    end
    drain();
    if (junk) begin
      repeat (2) tick_wait();
      i_bin_valid = 1'b0;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_bin_valid = 1'b0; i_bin_sop = 1'b0; i_bin_data = '0; i_hold_en = 1'b0;
    repeat (2) tick_wait();
    i_rst = 1'b0;

    // Reset state.
    for (int k = 0; k < 16; k++) chk("rst_data", 32'(o_fft_data[k]), 32'd0);
    chk("rst_done", 32'(o_fft_done), 32'd0);
    chk("rst_ready", 32'(o_bin_ready), 32'd1);

    // Ramp frame, hold off, with latency checks.
    for (int k = 0; k < 16; k++) begin
      stim[k] = 16'(k);
      expv[k] = 16'(k);
    end
    run_frame(1'b1, 1'b0);

    // Negative values and saturation.
    for (int k = 0; k < 16; k++) begin
      stim[k] = 16'h0000;
      expv[k] = 16'h0000;
    end
    stim[0] = 16'hFFFF; expv[0] = 16'd1;
    stim[3] = 16'h8000; expv[3] = 16'd32767;
    stim[4] = 16'hFFFB; expv[4] = 16'd5;
    stim[15] = 16'h7FFF; expv[15] = 16'd32767;
    run_frame(1'b0, 1'b0);

    // Reset at idx 7 with a bin offered on the reset cycle.
    for (int k = 0; k < 7; k++) send_bin(k == 0, 16'h0123);
    i_rst = 1'b1; i_bin_valid = 1'b1; i_bin_data = 16'h0456;
    tick_wait();
    i_rst = 1'b0; i_bin_valid = 1'b0;
    chk("midrst_b0", 32'(o_fft_data[0]), 32'd0);
    chk("midrst_b4", 32'(o_fft_data[4]), 32'd0);
    chk("midrst_ready", 32'(o_bin_ready), 32'd1);
    repeat (4) tick_wait();

    // Peak-hold with decay every 4th frame, counter restarted by the reset.
    i_hold_en = 1'b1;
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 16; k++) begin
        stim[k] = 16'h0000;
        expv[k] = 16'h0000;
      end
      if (f == 0) begin
        stim[0] = 16'd800;
        stim[1] = 16'hFFFB;
      end
      expv[0] = 16'(hold_e0[f]);
      expv[1] = 16'(hold_e1[f]);
      run_frame(1'b0, 1'b0);
    end
    i_hold_en = 1'b0;

    // sop at idx 9 restarts the frame.
    for (int k = 0; k < 9; k++) send_bin(k == 0, 16'h1111);
    for (int k = 0; k < 16; k++) begin
      stim[k] = 16'(100 + k);
      expv[k] = 16'(100 + k);
    end
    run_frame(1'b0, 1'b0);

    // Non-sop bins in IDLE, then valid held high through UPDATE/DONE.
    i_bin_valid = 1'b1; i_bin_sop = 1'b0; i_bin_data = 16'd999;
    repeat (4) tick_wait();
    i_bin_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      stim[k] = 16'(200 + k);
      expv[k] = 16'(200 + k);
    end
    run_frame(1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      stim[k] = 16'(300 + k);
      expv[k] = 16'(300 + k);
    end
    run_frame(1'b0, 1'b0);

    repeat (5) tick_wait();
    chk("final_queue", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
